// File: rtl/button_debouncer_multi.sv
// Multi-channel contact debouncer.
// Each channel is synchronised, then filtered against an external tick strobe.
// It produces a debounced level plus one-clock press, release and long-press pulses.
// The release pulse output is named 'rel' because 'release' is a reserved word.
module button_debouncer_multi #(
    parameter int N          = 4,
    parameter int STABLE     = 3,
    parameter int LONG       = 100,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         sync,
    output logic [N-1:0] out,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,
    output logic [N-1:0] long
);

    localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam int HW = $clog2(LONG + 1);

    logic [N-1:0]  meta;
    logic [N-1:0]  xs;
    logic [CW-1:0] cnt  [N];
    logic [HW-1:0] hold [N];

    // Two-flop synchroniser; polarity is normalised first so that reset (all zeros)
    // always corresponds to the released state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            xs   <= '0;
        end else begin
            meta <= in ^ {N{ACTIVE_LOW}};
            xs   <= meta;
        end
    end

    // Stability filter: a new level is accepted only after STABLE consecutive ticks that
    // all disagree with the current output. Any agreeing tick discards the partial count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out   <= '0;
            press <= '0;
            rel   <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            press <= '0;
            rel   <= '0;
            for (int i = 0; i < N; i++) begin
                if (sync) begin
                    if (xs[i] == out[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CW'(STABLE - 1)) begin
                        cnt[i]   <= '0;
                        out[i]   <= ~out[i];
                        press[i] <= ~out[i];
                        rel[i]   <= out[i];
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    // Long-press timer: counts ticks while the debounced level is high.
    // It saturates at LONG, so exactly one pulse is produced per press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long <= '0;
            for (int i = 0; i < N; i++) hold[i] <= '0;
        end else begin
            long <= '0;
            for (int i = 0; i < N; i++) begin
                if (!out[i]) begin
                    hold[i] <= '0;
                end else if (sync && (hold[i] < HW'(LONG))) begin
                    hold[i] <= hold[i] + HW'(1);
                    if (hold[i] == HW'(LONG - 1)) long[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Testbench for button_debouncer_multi.
// Two instances share clk and sync: one active-high and one active-low, both with STABLE=3 and LONG=8.
// A tick-level behavioural model predicts every output on every cycle.
module tb_button_debouncer_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync;
    logic [3:0] inA, inB;
    logic [3:0] outA, pressA, relA, longA;
    logic [3:0] outB, pressB, relB, longB;

    button_debouncer_multi #(.N(4), .STABLE(3), .LONG(8), .ACTIVE_LOW(1'b0)) dutA (
        .clk(clk), .rst(rst), .in(inA), .sync(sync),
        .out(outA), .press(pressA), .rel(relA), .long(longA)
    );

    button_debouncer_multi #(.N(4), .STABLE(3), .LONG(8), .ACTIVE_LOW(1'b1)) dutB (
        .clk(clk), .rst(rst), .in(inB), .sync(sync),
        .out(outB), .press(pressB), .rel(relB), .long(longB)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    int nAssert = 0;
    int nFail   = 0;

    // Model state for 8 channels: 0-3 are dutA, 4-7 are dutB.
    // Each channel keeps the history of pressed-ness and the run of disagreeing ticks.
    // It also keeps the ticks held high and the pulses due this cycle.
    bit mHist1 [8];
    bit mHist2 [8];
    int mRun   [8];
    int mHeld  [8];
    bit mOut   [8];
    bit mPress [8];
    bit mRel   [8];
    bit mLong  [8];

    int period   = 4;
    int phase    = 0;
    bit randSync = 1'b0;

    int pressCnt [4];
    int relCnt   [4];
    int longCnt  [4];
    bit saw1010Press, saw1010Rel;

    task automatic modelClear();
        for (int j = 0; j < 8; j++) begin
            mHist1[j] = 0; mHist2[j] = 0; mRun[j] = 0; mHeld[j] = 0;
            mOut[j] = 0; mPress[j] = 0; mRel[j] = 0; mLong[j] = 0;
        end
    endtask

    // One clock edge of the reference behaviour.
    // The level seen by the filter is the pressed-ness from two edges earlier.
    // A level is adopted after 3 disagreeing ticks in a row.
    // A long pulse fires on the 8th tick spent high.
    task automatic modelUpdate();
        bit x, seen, prev;
        if (!rst) begin
            modelClear();
            return;
        end
        for (int j = 0; j < 8; j++) begin
            x    = (j < 4) ? inA[j] : ~inB[j-4];
            seen = mHist2[j];
            mHist2[j] = mHist1[j];
            mHist1[j] = x;
            prev = mOut[j];
            mPress[j] = 0; mRel[j] = 0; mLong[j] = 0;
            if (!prev) mHeld[j] = 0;
            else if (sync && mHeld[j] < 8) begin
                mHeld[j]++;
                if (mHeld[j] == 8) mLong[j] = 1;
            end
            if (sync) begin
                if (seen != prev) begin
                    mRun[j]++;
                    if (mRun[j] == 3) begin
                        mRun[j]   = 0;
                        mOut[j]   = ~prev;
                        mPress[j] = ~prev;
                        mRel[j]   = prev;
                    end
                end else begin
                    mRun[j] = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Compare every output of both instances with the model
    task automatic checkOutput();
        logic [3:0] eo, ep, er, el, fo, fp, fr, fl;
        for (int k = 0; k < 4; k++) begin
            eo[k] = mOut[k];   ep[k] = mPress[k];   er[k] = mRel[k];   el[k] = mLong[k];
            fo[k] = mOut[k+4]; fp[k] = mPress[k+4]; fr[k] = mRel[k+4]; fl[k] = mLong[k+4];
        end
        check("outA", outA, eo);   check("pressA", pressA, ep);
        check("relA", relA, er);   check("longA", longA, el);
        check("outB", outB, fo);   check("pressB", pressB, fp);
        check("relB", relB, fr);   check("longB", longB, fl);
    endtask

    // Advance one clock: update the model at the rising edge, then check at the falling edge.
    // Next, drive the next sync value.
    task automatic cycle();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkOutput();
        for (int k = 0; k < 4; k++) begin
            pressCnt[k] += int'(pressA[k]);
            relCnt[k]   += int'(relA[k]);
            longCnt[k]  += int'(longA[k]);
        end
        if (pressA == 4'b1010) saw1010Press = 1'b1;
        if (relA == 4'b1010)   saw1010Rel   = 1'b1;
        phase++;
        sync = randSync ? ($urandom_range(0, 2) == 0) : ((phase % period) == 0);
    endtask

    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        inA = a;
        inB = b;
    endtask

    task automatic clearCounts();
        for (int k = 0; k < 4; k++) begin
            pressCnt[k] = 0; relCnt[k] = 0; longCnt[k] = 0;
        end
        saw1010Press = 1'b0;
        saw1010Rel   = 1'b0;
    endtask

    // Directed sequence followed by a randomized phase
    initial begin
        rst  = 1'b0;
        sync = 1'b0;
        modelClear();
        clearCounts();
        applyStimulus(4'b1111, 4'b0000);
        @(negedge clk);
        runCycles(12);
        check("reset_outA", outA, 4'b0000);
        check("reset_outB", outB, 4'b0000);

        rst = 1'b1;
        applyStimulus(4'b0000, 4'b1111);
        runCycles(20);

        $display("[TB] clean press on channel 0");
        clearCounts();
        applyStimulus(4'b0001, 4'b1111);
        runCycles(30);
        check("clean_out0", {3'b000, outA[0]}, 4'b0001);
        check("clean_press0", 4'(pressCnt[0]), 4'd1);

        $display("[TB] bounce on channel 1");
        clearCounts();
        for (int r = 0; r < 10; r++) begin
            applyStimulus(4'b0011, 4'b1111);
            runCycles(8);
            applyStimulus(4'b0001, 4'b1111);
            runCycles(4);
        end
        check("bounce_press1", 4'(pressCnt[1]), 4'd0);
        applyStimulus(4'b0011, 4'b1111);
        runCycles(20);
        check("bounce_out1", {3'b000, outA[1]}, 4'b0001);
        check("bounce_press1_after", 4'(pressCnt[1]), 4'd1);

        $display("[TB] long press on channel 2");
        clearCounts();
        applyStimulus(4'b0111, 4'b1111);
        runCycles(70);
        check("long_first", 4'(longCnt[2]), 4'd1);
        applyStimulus(4'b0011, 4'b1111);
        runCycles(30);
        check("long_release", 4'(relCnt[2]), 4'd1);
        applyStimulus(4'b0111, 4'b1111);
        runCycles(70);
        check("long_second", 4'(longCnt[2]), 4'd2);

        $display("[TB] simultaneous channels 1 and 3");
        applyStimulus(4'b0000, 4'b1111);
        runCycles(30);
        clearCounts();
        applyStimulus(4'b1010, 4'b1111);
        runCycles(30);
        check("simul_press", {3'b000, saw1010Press}, 4'b0001);
        check("simul_out", outA, 4'b1010);
        applyStimulus(4'b0000, 4'b1111);
        runCycles(30);
        check("simul_rel", {3'b000, saw1010Rel}, 4'b0001);

        $display("[TB] active-low channel 3 with reset mid-count");
        applyStimulus(4'b0000, 4'b0111);
        runCycles(9);
        rst = 1'b0;
        modelClear();
        runCycles(1);
        check("midreset_outB", outB, 4'b0000);
        rst = 1'b1;
        runCycles(24);
        check("requal_outB", outB, 4'b1000);

        $display("[TB] continuous sync");
        period = 1;
        applyStimulus(4'b0101, 4'b1111);
        runCycles(12);
        applyStimulus(4'b0000, 4'b0110);
        runCycles(12);

        $display("[TB] randomized phase");
        randSync = 1'b1;
        for (int r = 0; r < 150; r++) begin
            applyStimulus(4'($urandom), 4'($urandom));
            runCycles($urandom_range(1, 24));
            if (r == 75) begin
                rst = 1'b0;
                modelClear();
                runCycles(2);
                rst = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/button_debouncer_multi.md
Name: button_debouncer_multi

Overview:
Parametrised multi-channel successor to the single-button contact debouncer. Each of N channels is synchronised to clk and filtered against bounce. Filtering is timed by an external tick strobe (sync), and the stable-period length is configurable. Each channel provides a debounced level plus one-clock press, release and long-press event pulses for downstream control logic.

Parameters:
N, 4, number of independent button channels (>=1)
STABLE, 3, consecutive sync ticks of unchanged input needed to accept a new level (>=1)
LONG, 100, sync ticks the debounced level must stay 1 before a long-press pulse (>=1)
ACTIVE_LOW, 0, 1 = raw inputs are active-low (inverted before synchronisation), 0 = active-high

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
in  input  N  raw button inputs, asynchronous to clk
sync  input  1  tick strobe from external timer, one clk wide typ.; every clk with sync=1 counts as one tick
out  output  N  debounced level per channel (1 = pressed)
press  output  N  one-clk pulse on debounced 0->1
release  output  N  one-clk pulse on debounced 1->0
long  output  N  one-clk pulse when channel held LONG ticks

Behaviour:
- Reset (rst=0, async): out, press, release, long = 0; all counters = 0; synchroniser flops = 0 (inactive level).
- Polarity: x = in XOR {N{ACTIVE_LOW}}, applied before the synchroniser.
- Synchroniser: 2 flops per channel, clocked every clk independent of sync. x_s = x delayed 2 clk.
- Stability counter per channel, width clog2(STABLE) (min 1 bit). Updates only on clk with sync=1:
  - x_s == out: cnt <= 0.
  - x_s != out and cnt < STABLE-1: cnt <= cnt+1.
  - x_s != out and cnt == STABLE-1: out toggles, cnt <= 0.
  - STABLE=1: toggles on first tick with differing x_s.
- Bounce: any tick with x_s == out clears cnt. Partial accumulation never carries over.
- sync=0: cnt and out hold. A glitch shorter than the tick spacing that is not present at a tick is ignored.
- Latency: raw edge -> out change = 2 clk + STABLE ticks (the final tick's clk edge registers out).
- press[i] / release[i]: registered, high for exactly the one clk in which out[i] has just changed (same cycle as the new out value). Never both high on one channel.
- Long-press counter per channel, width clog2(LONG+1), saturating:
  - out=0: hold <= 0.
  - out=1, sync=1, hold < LONG: hold <= hold+1.
  - hold reaching LONG asserts long[i] for one clk (aligned with the registered increment). No further long pulse until out returns to 0 and is pressed again.
  - Counting starts on the first tick after the clk in which out rose. That tick counts as 1.
- Channels are fully independent. Simultaneous events on several channels produce same-cycle pulses in the corresponding bits.
- Reset mid-operation: all state clears immediately. After release of rst, a held input is re-qualified from scratch (2 clk + STABLE ticks). A press pulse is then issued.
- sync held high continuously: each clk is a tick. Legal.

Test Plan:
- Reset: rst=0, in=4'b1111, sync toggling -> out/press/release/long remain 0. Release rst with in=4'b0000 -> outputs stay 0.
- Clean press, N=4, STABLE=3, sync every 4 clk: in[0] 0->1 held -> out[0]=1 on the 3rd tick after x_s[0]=1. press[0]=1 for that single clk. Other bits stay 0.
- Bounce: in[1] pattern 1 for 2 ticks, 0 for 1 tick, repeated 10x -> out[1] stays 0, no pulses. Then held 1 for 3 ticks -> out[1]=1, one press pulse.
- Long press, LONG=8: hold in[2] -> long[2] pulses exactly once, on the 8th tick after out[2] rose. Release -> release[2] after 3 ticks. Re-press -> second long pulse after 8 more ticks.
- Simultaneous: in 4'b0000->4'b1010 at one edge -> press=4'b1010 in a single clk, out=4'b1010. Later in->4'b0000 -> release=4'b1010 in a single clk.
- Reset mid-count and polarity: ACTIVE_LOW=1, in[3]=0 (pressed) for 2 ticks, pull rst low 1 clk -> cnt cleared, out[3]=0. Keep in[3]=0 -> out[3]=1 only after 2 clk + 3 full ticks following reset release.
